// File: rtl/ah_ddr2pl_reader.sv
// AXI4 read-only master: fetches NUM_BURSTS fixed-length INCR bursts from
// START_ADDR and forwards the beats as a valid/ready stream to the PL.
// Same INIT / TXN_DONE / ERROR control triple as the PL2DDR writer.
module ah_ddr2pl_reader #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_BURST_LEN  = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          INIT_AXI_TXN,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] START_ADDR,
   input  logic [15:0]                   NUM_BURSTS,
   output logic                          BUSY,
   output logic                          TXN_DONE,
   output logic                          ERROR,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] DOUT,
   output logic                          DOUT_VALID,
   output logic                          DOUT_LAST,
   input  logic                          DOUT_READY
);

   localparam logic [7:0] ARLEN_C = 8'(C_M_AXI_BURST_LEN - 1);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] STEP = C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * 4);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef struct packed {
      logic [C_M_AXI_DATA_WIDTH-1:0] data;
      logic                          last;
   } beat_t;

   logic [2:0]                    state;
   logic                          init_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] araddr;
   logic [15:0]                   nb_q;
   logic [15:0]                   burst_cnt;
   logic [7:0]                    beat_cnt;
   logic                          busy;
   logic                          txn_done;
   logic                          error;
   beat_t                         out_q;
   logic                          out_vld;

   logic start, r_hs, exp_last, burst_end, last_burst;

   assign start      = (state == ST_IDLE) && INIT_AXI_TXN && !init_q;
   assign exp_last   = (beat_cnt == ARLEN_C);
   // An early RLAST still closes the burst; a missing RLAST is implied by the count.
   assign burst_end  = M_AXI_RLAST || exp_last;
   assign last_burst = (burst_cnt == nb_q - 16'd1);
   // Only one burst is ever outstanding, so R beats are taken in DATA alone.
   assign M_AXI_RREADY = (state == ST_DATA) && (!out_vld || DOUT_READY);
   assign r_hs       = M_AXI_RVALID && M_AXI_RREADY;

   assign M_AXI_ARADDR  = araddr;
   assign M_AXI_ARLEN   = ARLEN_C;
   assign M_AXI_ARSIZE  = 3'b010;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARVALID = (state == ST_ADDR);

   assign BUSY       = busy;
   assign TXN_DONE   = txn_done;
   assign ERROR      = error;
   assign DOUT       = out_q.data;
   assign DOUT_LAST  = out_q.last;
   assign DOUT_VALID = out_vld;

   // Job control FSM: start detect, address issue, beat counting, error flagging.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= ST_IDLE;
         init_q    <= INIT_AXI_TXN;
         araddr    <= '0;
         nb_q      <= '0;
         burst_cnt <= '0;
         beat_cnt  <= '0;
         busy      <= 1'b0;
         txn_done  <= 1'b0;
         error     <= 1'b0;
      end else begin
         init_q   <= INIT_AXI_TXN;
         txn_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  araddr    <= START_ADDR;
                  nb_q      <= NUM_BURSTS;
                  burst_cnt <= '0;
                  beat_cnt  <= '0;
                  error     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= (NUM_BURSTS == 16'd0) ? ST_DONE : ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (M_AXI_ARREADY) state <= ST_DATA;
            end
            ST_DATA: begin
               if (r_hs) begin
                  if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != exp_last)) error <= 1'b1;
                  if (burst_end) begin
                     beat_cnt  <= '0;
                     burst_cnt <= burst_cnt + 16'd1;
                     araddr    <= araddr + STEP;
                     state     <= last_burst ? ST_DRAIN : ST_ADDR;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            // Hold off completion until the final word has been taken downstream.
            ST_DRAIN: begin
               if (out_vld && DOUT_READY) state <= ST_DONE;
            end
            ST_DONE: begin
               txn_done <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered stream output; refilled in the same cycle it drains, so no bubbles.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         out_q   <= '0;
         out_vld <= 1'b0;
      end else if (r_hs) begin
         out_q.data <= M_AXI_RDATA;
         out_q.last <= burst_end && last_burst;
         out_vld    <= 1'b1;
      end else if (DOUT_READY) begin
         out_vld    <= 1'b0;
         out_q.last <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ah_ddr2pl_reader.sv
// Scoreboard bench for ah_ddr2pl_reader: a small AXI read slave model serves
// word[i]=i relative to the job base; expected AR addresses and stream words
// are queued at job start and popped by an independent monitor.
module tb_ah_ddr2pl_reader;

   logic        ACLK = 1'b0;
   logic        ARESET, INIT_AXI_TXN;
   logic [31:0] START_ADDR;
   logic [15:0] NUM_BURSTS;
   logic        BUSY, TXN_DONE, ERROR;
   logic [31:0] M_AXI_ARADDR;
   logic [7:0]  M_AXI_ARLEN;
   logic [2:0]  M_AXI_ARSIZE;
   logic [1:0]  M_AXI_ARBURST;
   logic        M_AXI_ARVALID, M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
   logic [31:0] DOUT;
   logic        DOUT_VALID, DOUT_LAST, DOUT_READY;

   ah_ddr2pl_reader dut (
      .ACLK(ACLK), .ARESET(ARESET), .INIT_AXI_TXN(INIT_AXI_TXN),
      .START_ADDR(START_ADDR), .NUM_BURSTS(NUM_BURSTS),
      .BUSY(BUSY), .TXN_DONE(TXN_DONE), .ERROR(ERROR),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
      .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY),
      .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_LAST(DOUT_LAST),
      .DOUT_READY(DOUT_READY)
   );

   always #5 ACLK = ~ACLK;

   int          compared = 0;
   int          mismatched = 0;
   int          done_cnt = 0;
   int          ar_cnt = 0;
   logic [31:0] exp_ar[$];
   logic [32:0] exp_q[$];
   logic [31:0] base = 32'h0;
   bit          gaps = 1'b0;
   bit          rdy_rand = 1'b0;
   bit          err_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      compared++;
      mismatched++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // AXI read slave model: one burst at a time, optional ARREADY/RVALID gaps.
   logic [31:0] rd_addr = 32'h0;
   int          rd_beat = 0;
   bit          rd_active = 1'b0;
   bit          s_rst, s_ar, s_r;
   logic [31:0] s_ar_addr;
   initial begin
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
      M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
      forever begin
         @(negedge ACLK);
         s_rst = ARESET;
         s_ar = M_AXI_ARVALID && M_AXI_ARREADY;
         s_ar_addr = M_AXI_ARADDR;
         s_r = M_AXI_RVALID && M_AXI_RREADY;
         @(posedge ACLK); #1;
         if (s_rst) begin
            rd_active = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0; M_AXI_RLAST = 1'b0;
         end else begin
            if (s_r) begin
               rd_beat++; rd_addr += 32'd4;
               if (rd_beat == 16) rd_active = 1'b0;
            end
            if (s_ar) begin rd_active = 1'b1; rd_addr = s_ar_addr; rd_beat = 0; end
            M_AXI_ARREADY = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!(M_AXI_RVALID && !s_r))
               M_AXI_RVALID = rd_active && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
            M_AXI_RDATA = (rd_addr - base) >> 2;
            M_AXI_RRESP = (err_en && (rd_addr - base) == 32'd20) ? 2'b10 : 2'b00;
            M_AXI_RLAST = (rd_beat == 15);
         end
      end
   end

   // Downstream ready: always on, or pseudo-random back-pressure.
   initial begin
      DOUT_READY = 1'b1;
      forever begin
         @(posedge ACLK); #1;
         DOUT_READY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: checks AR and stream transfers against the queues, stall stability.
   bit          stall_pend = 1'b0;
   logic [31:0] held_d;
   logic        held_l;
   logic [31:0] e_ar;
   logic [32:0] e_w;
   initial begin
      forever begin
         @(negedge ACLK);
         if (ARESET) stall_pend = 1'b0;
         else begin
            if (TXN_DONE) done_cnt++;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               ar_cnt++;
               if (exp_ar.size() == 0) fail("unexpected_ar");
               else begin
                  e_ar = exp_ar.pop_front();
                  chk("araddr", M_AXI_ARADDR, e_ar);
               end
               chk("ar_consts", {M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}, {8'd15, 3'b010, 2'b01});
            end
            if (stall_pend) begin
               chk("stall_hold", {DOUT_VALID, DOUT_LAST, DOUT}, {1'b1, held_l, held_d});
            end
            if (DOUT_VALID && DOUT_READY) begin
               if (exp_q.size() == 0) fail("unexpected_word");
               else begin
                  e_w = exp_q.pop_front();
                  chk("dout", DOUT, e_w[31:0]);
                  chk("dout_last", DOUT_LAST, e_w[32]);
               end
            end
            stall_pend = DOUT_VALID && !DOUT_READY;
            held_d = DOUT; held_l = DOUT_LAST;
         end
      end
   end

   task automatic start_job(input logic [31:0] a, input logic [15:0] nb, input bit hold);
      base = a; START_ADDR = a; NUM_BURSTS = nb;
      for (int k = 0; k < int'(nb); k++) exp_ar.push_back(a + 32'(k * 64));
      for (int i = 0; i < int'(nb) * 16; i++)
         exp_q.push_back({(i == int'(nb) * 16 - 1), 32'(i)});
      @(posedge ACLK); #1; INIT_AXI_TXN = 1'b1;
      if (!hold) begin @(posedge ACLK); #1; INIT_AXI_TXN = 1'b0; end
   endtask

   task automatic wait_done(input int d0, input string nm);
      int n = 0;
      while (done_cnt == d0 && n < 3000) begin @(posedge ACLK); n++; end
      if (done_cnt == d0) fail({nm, "_timeout"});
      repeat (8) @(posedge ACLK);
      #1;
      chk({nm, "_done_pulses"}, done_cnt, d0 + 1);
      chk({nm, "_words_left"}, exp_q.size(), 0);
      chk({nm, "_ars_left"}, exp_ar.size(), 0);
      chk({nm, "_busy"}, BUSY, 1'b0);
   endtask

   int d0, a0, n;
   initial begin
      ARESET = 1'b1; INIT_AXI_TXN = 1'b0; START_ADDR = '0; NUM_BURSTS = '0;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      chk("reset_ctrl", {BUSY, TXN_DONE, ERROR, M_AXI_ARVALID, M_AXI_RREADY, DOUT_VALID, DOUT_LAST}, 7'b0);
      chk("reset_addr_data", {M_AXI_ARADDR, DOUT}, 64'h0);

      // 1: two bursts, no back-pressure
      d0 = done_cnt;
      start_job(32'h1000_0000, 16'd2, 1'b0);
      wait_done(d0, "t1");
      chk("t1_error", ERROR, 1'b0);

      // 2: same job with RVALID gaps, ARREADY gaps and random DOUT_READY
      gaps = 1'b1; rdy_rand = 1'b1;
      d0 = done_cnt;
      start_job(32'h1000_0000, 16'd2, 1'b0);
      wait_done(d0, "t2");
      chk("t2_error", ERROR, 1'b0);
      gaps = 1'b0; rdy_rand = 1'b0;

      // 3: SLVERR on word 5 of burst 0
      err_en = 1'b1;
      d0 = done_cnt;
      start_job(32'h1000_0000, 16'd2, 1'b0);
      wait_done(d0, "t3");
      chk("t3_error", ERROR, 1'b1);
      repeat (4) @(posedge ACLK);
      #1 chk("t3_error_sticky", ERROR, 1'b1);
      err_en = 1'b0;

      // 4: zero bursts: BUSY one cycle, TXN_DONE two edges after INIT
      d0 = done_cnt; a0 = ar_cnt;
      start_job(32'h1000_0000, 16'd0, 1'b0);
      @(negedge ACLK);
      chk("t4_edge1", {BUSY, TXN_DONE, ERROR}, 3'b100);
      @(negedge ACLK);
      chk("t4_edge2", {BUSY, TXN_DONE}, 2'b01);
      @(negedge ACLK);
      chk("t4_edge3", {BUSY, TXN_DONE}, 2'b00);
      chk("t4_no_ar", ar_cnt, a0);
      chk("t4_done_pulses", done_cnt, d0 + 1);

      // 5: reset during burst 1 data phase, then a clean job that wraps the address
      err_en = 1'b1;
      d0 = done_cnt; a0 = ar_cnt; n = 0;
      start_job(32'h1000_0000, 16'd2, 1'b0);
      while (ar_cnt < a0 + 2 && n < 500) begin @(posedge ACLK); n++; end
      if (ar_cnt < a0 + 2) fail("t5_ar_timeout");
      repeat (3) @(posedge ACLK);
      #1;
      chk("t5_pre_busy_err", {BUSY, ERROR}, 2'b11);
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      exp_q.delete(); exp_ar.delete();
      err_en = 1'b0;
      @(negedge ACLK);
      chk("t5_rst_ctrl", {BUSY, TXN_DONE, ERROR, M_AXI_ARVALID, M_AXI_RREADY, DOUT_VALID, DOUT_LAST}, 7'b0);
      chk("t5_rst_addr_data", {M_AXI_ARADDR, DOUT}, 64'h0);
      repeat (5) @(posedge ACLK);
      #1 chk("t5_no_done", done_cnt, d0);
      d0 = done_cnt;
      start_job(32'hFFFF_FFC0, 16'd2, 1'b0);
      wait_done(d0, "t5_clean");
      chk("t5_clean_error", ERROR, 1'b0);

      // 6: INIT held high, then re-pulsed mid-job: a single job only
      d0 = done_cnt;
      start_job(32'h1000_0000, 16'd2, 1'b1);
      repeat (5) @(posedge ACLK);
      #1 INIT_AXI_TXN = 1'b0;
      repeat (3) @(posedge ACLK);
      #1 INIT_AXI_TXN = 1'b1;
      @(posedge ACLK); #1 INIT_AXI_TXN = 1'b0;
      wait_done(d0, "t6");
      repeat (20) @(posedge ACLK);
      #1 chk("t6_single_job", done_cnt, d0 + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
